id_ex_stage: RTL and testbench

- ID/EX pipeline register with operand forwarding and load-use hazard detection for the 5-stage MIPS pipeline.
- Sits directly upstream of the ALU and drives its aluControl, input1, input2 and shamt inputs.
- Also carries the control and destination fields that EX/MEM needs.
- Operand order is fixed: input1 = rs side, input2 = rt/immediate side. The ALU computes SUB as input2 - input1, and shifts operate on input2.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/forward_unit.sv | 38 +++
 rtl/id_ex_stage.sv | 138 +++++++++++++
 tb/tb_id_ex_stage.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared constants for the MIPS pipeline: datapath widths, ALU opcodes,
// register $0 and the forwarding-select encoding.
package mips_pkg;

  localparam int DATA_W   = 32;
  localparam int REG_AW   = 5;
  localparam int REG_ZERO = 0;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_OR   = 4'd1;
  localparam logic [3:0] ALU_ADD  = 4'd2;
  localparam logic [3:0] ALU_SUB  = 4'd6;
  localparam logic [3:0] ALU_SLT  = 4'd7;
  localparam logic [3:0] ALU_SLTU = 4'd8;
  localparam logic [3:0] ALU_SHL  = 4'd9;
  localparam logic [3:0] ALU_SHR  = 4'd10;
  localparam logic [3:0] ALU_NOR  = 4'd12;

  typedef enum logic [1:0] {
    FWD_REG   = 2'b00,
    FWD_MEMWB = 2'b01,
    FWD_EXMEM = 2'b10
  } fwd_sel_e;

endpackage

// File: rtl/forward_unit.sv
// Combinational forwarding comparator: picks the youngest in-flight producer
// of each EX operand, with register $0 never forwarded.
module forward_unit
  import mips_pkg::*;
#(
  parameter int REG_AW = mips_pkg::REG_AW
) (
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  output logic [1:0]        fwd_rs,
  output logic [1:0]        fwd_rt
);

  logic [REG_AW-1:0] src [2];
  logic [1:0]        sel [2];

  assign src[0] = ex_rs;
  assign src[1] = ex_rt;

  // EX/MEM is checked first so the most recent producer wins on a double match.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_op
      assign sel[gi] =
        (exmem_reg_write && (exmem_rd != REG_AW'(REG_ZERO)) && (exmem_rd == src[gi])) ? FWD_EXMEM :
        (memwb_reg_write && (memwb_rd != REG_AW'(REG_ZERO)) && (memwb_rd == src[gi])) ? FWD_MEMWB :
                                                                                          FWD_REG;
    end
  endgenerate

  assign fwd_rs = sel[0];
  assign fwd_rt = sel[1];

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with writeback write-through at capture,
// EX-side operand forwarding and load-use hazard detection.
module id_ex_stage
  import mips_pkg::*;
#(
  parameter int DATA_W = mips_pkg::DATA_W,
  parameter int REG_AW = mips_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic [4:0]        id_shamt,
  input  logic [3:0]        id_alu_ctrl,
  input  logic              id_alu_src,
  input  logic              id_reg_dst,
  input  logic              id_uses_rt,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              id_mem_write,
  input  logic              id_mem_to_reg,
  input  logic              exmem_reg_write,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic [DATA_W-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [REG_AW-1:0] memwb_rd,
  input  logic [DATA_W-1:0] memwb_result,
  output logic              hazard_stall,
  output logic [3:0]        alu_control,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [4:0]        alu_shamt,
  output logic [DATA_W-1:0] ex_store_data,
  output logic [REG_AW-1:0] ex_dest,
  output logic              ex_valid,
  output logic              ex_reg_write,
  output logic              ex_mem_read,
  output logic              ex_mem_write,
  output logic              ex_mem_to_reg
);

  logic [DATA_W-1:0] rs_data_reg;
  logic [DATA_W-1:0] rt_data_reg;
  logic [DATA_W-1:0] imm_reg;
  logic [REG_AW-1:0] rs_reg;
  logic [REG_AW-1:0] rt_reg;
  logic              alu_src_reg;

  logic              wt_rs;
  logic              wt_rt;
  logic [1:0]        fwd_rs;
  logic [1:0]        fwd_rt;
  logic [DATA_W-1:0] rs_fwd;
  logic [DATA_W-1:0] rt_fwd;

  // A load in EX whose destination is read by the ID instruction cannot be
  // forwarded in time; hold ID for one cycle and inject a bubble.
  assign hazard_stall = ex_valid & ex_mem_read & (ex_dest != REG_AW'(REG_ZERO)) & id_valid &
                        ((ex_dest == id_rs) | (id_uses_rt & (ex_dest == id_rt)));

  // Register file writes in the same cycle it is read, so catch that value here.
  assign wt_rs = memwb_reg_write && (memwb_rd != REG_AW'(REG_ZERO)) && (memwb_rd == id_rs);
  assign wt_rt = memwb_reg_write && (memwb_rd != REG_AW'(REG_ZERO)) && (memwb_rd == id_rt);

  always_ff @(posedge clk) begin
    if (rst || flush || (hazard_stall && !stall)) begin
      ex_valid      <= 1'b0;
      ex_reg_write  <= 1'b0;
      ex_mem_read   <= 1'b0;
      ex_mem_write  <= 1'b0;
      ex_mem_to_reg <= 1'b0;
      alu_control   <= ALU_AND;
      alu_shamt     <= '0;
      ex_dest       <= '0;
      alu_src_reg   <= 1'b0;
      rs_reg        <= '0;
      rt_reg        <= '0;
      rs_data_reg   <= '0;
      rt_data_reg   <= '0;
      imm_reg       <= '0;
    end else if (!stall) begin
      ex_valid      <= id_valid;
      ex_reg_write  <= id_valid & id_reg_write;
      ex_mem_read   <= id_valid & id_mem_read;
      ex_mem_write  <= id_valid & id_mem_write;
      ex_mem_to_reg <= id_valid & id_mem_to_reg;
      alu_control   <= id_alu_ctrl;
      alu_shamt     <= id_shamt;
      ex_dest       <= id_reg_dst ? id_rd : id_rt;
      alu_src_reg   <= id_alu_src;
      rs_reg        <= id_rs;
      rt_reg        <= id_rt;
      rs_data_reg   <= wt_rs ? memwb_result : id_rs_data;
      rt_data_reg   <= wt_rt ? memwb_result : id_rt_data;
      imm_reg       <= id_imm;
    end
  end

  forward_unit #(
    .REG_AW(REG_AW)
  ) u_forward_unit (
    .ex_rs           (rs_reg),
    .ex_rt           (rt_reg),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .fwd_rs          (fwd_rs),
    .fwd_rt          (fwd_rt)
  );

  always_comb begin
    rs_fwd = rs_data_reg;
    rt_fwd = rt_data_reg;
    case (fwd_rs)
      FWD_EXMEM: rs_fwd = exmem_result;
      FWD_MEMWB: rs_fwd = memwb_result;
      default:   rs_fwd = rs_data_reg;
    endcase
    case (fwd_rt)
      FWD_EXMEM: rt_fwd = exmem_result;
      FWD_MEMWB: rt_fwd = memwb_result;
      default:   rt_fwd = rt_data_reg;
    endcase
  end

  assign alu_in1       = rs_fwd;
  assign ex_store_data = rt_fwd;
  assign alu_in2       = alu_src_reg ? imm_reg : rt_fwd;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios plus randomized traffic checked
// against an instruction-level model of what the EX stage should hold.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst, stall, flush, id_valid;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic [4:0]  id_rs, id_rt, id_rd, id_shamt;
  logic [3:0]  id_alu_ctrl;
  logic        id_alu_src, id_reg_dst, id_uses_rt;
  logic        id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        hazard_stall;
  logic [3:0]  alu_control;
  logic [31:0] alu_in1, alu_in2, ex_store_data;
  logic [4:0]  alu_shamt, ex_dest;
  logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_shamt(id_shamt),
    .id_alu_ctrl(id_alu_ctrl), .id_alu_src(id_alu_src), .id_reg_dst(id_reg_dst),
    .id_uses_rt(id_uses_rt), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .id_mem_write(id_mem_write), .id_mem_to_reg(id_mem_to_reg),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .hazard_stall(hazard_stall), .alu_control(alu_control), .alu_in1(alu_in1),
    .alu_in2(alu_in2), .alu_shamt(alu_shamt), .ex_store_data(ex_store_data),
    .ex_dest(ex_dest), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_mem_to_reg(ex_mem_to_reg)
  );

  // Model of the instruction sitting in EX; known=0 means its data fields are don't-care.
  typedef struct {
    logic        known, v, rw, mr, mw, m2r, src;
    logic [3:0]  ctl;
    logic [4:0]  rs, rt, dest, sh;
    logic [31:0] rsv, rtv, imm;
  } ex_t;

  ex_t         m;
  logic        m_live = 1'b0;
  int          pass_cnt = 0;
  int          total_cnt = 0;
  int          txn = 0;
  logic [31:0] held;
  logic [3:0]  ops [9] = '{4'd0, 4'd1, 4'd2, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd12};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] regv);
    if (exmem_reg_write && exmem_rd != 0 && exmem_rd == idx) return exmem_result;
    if (memwb_reg_write && memwb_rd != 0 && memwb_rd == idx) return memwb_result;
    return regv;
  endfunction

  function automatic logic exp_hazard();
    return m.v && m.mr && m.dest != 0 && id_valid &&
           (m.dest == id_rs || (id_uses_rt && m.dest == id_rt));
  endfunction

  task automatic set_idle();
    {rst, stall, flush, id_valid} = '0;
    {id_rs_data, id_rt_data, id_imm} = '0;
    {id_rs, id_rt, id_rd, id_shamt, id_alu_ctrl} = '0;
    {id_alu_src, id_reg_dst, id_uses_rt} = '0;
    {id_reg_write, id_mem_read, id_mem_write, id_mem_to_reg} = '0;
    {exmem_reg_write, exmem_rd, exmem_result} = '0;
    {memwb_reg_write, memwb_rd, memwb_result} = '0;
  endtask

  task automatic check_model();
    check("hazard", 32'(hazard_stall), 32'(exp_hazard()));
    check("valid", 32'(ex_valid), 32'(m.v));
    check("reg_write", 32'(ex_reg_write), 32'(m.rw));
    check("mem_read", 32'(ex_mem_read), 32'(m.mr));
    check("mem_write", 32'(ex_mem_write), 32'(m.mw));
    if (m.known) begin
      check("mem_to_reg", 32'(ex_mem_to_reg), 32'(m.m2r));
      check("alu_control", 32'(alu_control), 32'(m.ctl));
      check("shamt", 32'(alu_shamt), 32'(m.sh));
      check("dest", 32'(ex_dest), 32'(m.dest));
      check("alu_in1", alu_in1, fwd(m.rs, m.rsv));
      check("alu_in2", alu_in2, m.src ? m.imm : fwd(m.rt, m.rtv));
      check("store_data", ex_store_data, fwd(m.rt, m.rtv));
    end
  endtask

  // Settle inputs, check outputs, clock once, then advance the model.
  task automatic step();
    logic hz;
    #2;
    hz = exp_hazard();
    if (m_live) check_model();
    @(posedge clk);
    if (rst) begin
      m = '{known: 1'b1, default: '0};
      m_live = 1'b1;
    end else if (flush || (hz && !stall)) begin
      m.known = 1'b0; m.v = 1'b0; m.rw = 1'b0; m.mr = 1'b0; m.mw = 1'b0;
    end else if (!stall) begin
      m.known = 1'b1;
      m.v   = id_valid;
      m.rw  = id_valid & id_reg_write;
      m.mr  = id_valid & id_mem_read;
      m.mw  = id_valid & id_mem_write;
      m.m2r = id_valid & id_mem_to_reg;
      m.src = id_alu_src; m.ctl = id_alu_ctrl; m.sh = id_shamt;
      m.rs = id_rs; m.rt = id_rt; m.imm = id_imm;
      m.dest = id_reg_dst ? id_rd : id_rt;
      m.rsv = (memwb_reg_write && memwb_rd != 0 && memwb_rd == id_rs) ? memwb_result : id_rs_data;
      m.rtv = (memwb_reg_write && memwb_rd != 0 && memwb_rd == id_rt) ? memwb_result : id_rt_data;
    end
    txn++;
    $display("txn %0d: rst=%0b flush=%0b stall=%0b hz=%0b id_v=%0b -> model valid=%0b dest=%0d",
             txn, rst, flush, stall, hz, id_valid, m.v, m.dest);
    #1;
  endtask

  initial begin
    set_idle();
    @(negedge clk);

    // Reset with a live instruction presented
    rst = 1'b1; id_valid = 1'b1; id_reg_write = 1'b1; id_mem_read = 1'b1;
    id_rs_data = 32'h1234; id_rs = 5'd1;
    step(); step();
    set_idle(); #1;
    check("rst_valid", 32'(ex_valid), 32'd0);
    check("rst_in1", alu_in1, 32'd0);
    check("rst_in2", alu_in2, 32'd0);
    check("rst_ctrl", 32'({ex_reg_write, ex_mem_read, ex_mem_write, ex_mem_to_reg}), 32'd0);
    check("rst_hazard", 32'(hazard_stall), 32'd0);

    // add $3,$1,$2
    id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3; id_reg_dst = 1'b1;
    id_rs_data = 32'd5; id_rt_data = 32'd7; id_alu_ctrl = 4'd2; id_reg_write = 1'b1; id_uses_rt = 1'b1;
    step();
    set_idle(); #1;
    check("add_in1", alu_in1, 32'd5);
    check("add_in2", alu_in2, 32'd7);
    check("add_ctrl", 32'(alu_control), 32'd2);
    check("add_dest", 32'(ex_dest), 32'd3);

    // Double-forward priority on rs=$4
    id_valid = 1'b1; id_rs = 5'd4; id_rs_data = 32'h99; id_alu_ctrl = 4'd2;
    step();
    set_idle();
    exmem_reg_write = 1'b1; exmem_rd = 5'd4; exmem_result = 32'h11;
    memwb_reg_write = 1'b1; memwb_rd = 5'd4; memwb_result = 32'h22;
    #1 check("fwd_exmem_wins", alu_in1, 32'h11);
    exmem_rd = 5'd0;
    #1 check("fwd_memwb", alu_in1, 32'h22);
    step();

    // Load-use: lw $5 then sub reading rt=$5
    set_idle();
    id_valid = 1'b1; id_mem_read = 1'b1; id_reg_write = 1'b1; id_rt = 5'd5; id_rs = 5'd2;
    step();
    set_idle();
    id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd5; id_rd = 5'd7; id_reg_dst = 1'b1;
    id_uses_rt = 1'b1; id_alu_ctrl = 4'd6; id_reg_write = 1'b1;
    #1 check("loaduse_hz", 32'(hazard_stall), 32'd1);
    step();
    check("loaduse_bubble", 32'(ex_valid), 32'd0);
    check("loaduse_once", 32'(hazard_stall), 32'd0);
    step();
    check("loaduse_issue", 32'(ex_dest), 32'd7);
    set_idle();
    id_valid = 1'b1; id_mem_read = 1'b1; id_rt = 5'd5;
    step();
    set_idle();
    id_valid = 1'b1; id_rs = 5'd1; id_rt = 5'd5; id_uses_rt = 1'b0;
    #1 check("no_hz_imm", 32'(hazard_stall), 32'd0);
    step();

    // Stall for three cycles with other inputs changing, then flush+stall
    set_idle();
    id_valid = 1'b1; id_rs = 5'd9; id_rs_data = 32'hCAFE; id_reg_write = 1'b1; id_rd = 5'd9; id_reg_dst = 1'b1;
    step();
    set_idle(); #1;
    held = alu_in1;
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      id_valid = 1'b1; id_rs_data = $urandom; id_rs = 5'($urandom);
      step();
      check("stall_hold_in1", alu_in1, held);
      check("stall_hold_valid", 32'(ex_valid), 32'd1);
    end
    flush = 1'b1;
    step();
    check("flush_stall", 32'(ex_valid), 32'd0);

    // Writeback write-through at capture
    set_idle();
    id_valid = 1'b1; id_rs = 5'd6; id_rs_data = 32'd0;
    memwb_reg_write = 1'b1; memwb_rd = 5'd6; memwb_result = 32'hABCD;
    step();
    memwb_reg_write = 1'b0; id_valid = 1'b0; #1;
    check("wt_rs", alu_in1, 32'hABCD);
    id_valid = 1'b1; memwb_reg_write = 1'b1; memwb_rd = 5'd0;
    step();
    memwb_reg_write = 1'b0; id_valid = 1'b0; #1;
    check("wt_zero", alu_in1, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 300; n++) begin
      rst   = ($urandom_range(99) < 3);
      flush = ($urandom_range(99) < 10);
      stall = ($urandom_range(99) < 15);
      id_valid = ($urandom_range(99) < 85);
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
      id_rs = 5'($urandom_range(7)); id_rt = 5'($urandom_range(7)); id_rd = 5'($urandom_range(7));
      id_shamt = 5'($urandom); id_alu_ctrl = ops[$urandom_range(8)];
      {id_alu_src, id_reg_dst, id_uses_rt, id_reg_write, id_mem_write, id_mem_to_reg} = 6'($urandom);
      id_mem_read = ($urandom_range(99) < 35);
      exmem_reg_write = 1'($urandom); exmem_rd = 5'($urandom_range(7)); exmem_result = $urandom;
      memwb_reg_write = 1'($urandom); memwb_rd = 5'($urandom_range(7)); memwb_result = $urandom;
      step();
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
